// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - PS/2 receiver FIFO handshake bundle
interface ps2_key_decoder_if;
  // Head of the receiver FIFO, valid while ready is high
  logic [7:0] data;
  // Receiver FIFO non-empty
  logic       ready;
  // Receiver FIFO overflow indication
  logic       overflow;
  // Active-low pop, one cycle per consumed byte
  logic       nextdata_n;

  // FIFO side: presents bytes, observes pops
  modport master (
    output data,
    output ready,
    output overflow,
    input  nextdata_n
  );

  // Decoder side: consumes bytes, issues pops
  modport slave (
    input  data,
    input  ready,
    input  overflow,
    output nextdata_n
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 scan-code decoder with make/break tracking
module ps2_key_decoder (
  input  logic                  clk,
  input  logic                  rst,
  ps2_key_decoder_if.slave      rx,
  output logic [7:0]            key_code,
  output logic                  key_ext,
  output logic [7:0]            key_ascii,
  output logic                  key_down,
  output logic                  key_event,
  output logic [7:0]            press_count,
  output logic                  ovf_seen
);

  localparam logic [7:0] BRK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX = 8'hE0;

  // IDLE waits for a byte and pops it; ACK decodes it and guarantees
  // the pop strobe is released before the FIFO head is looked at again.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t     state_q;
  logic       nextdata_n_q;
  logic [7:0] byte_q;
  logic       brk_pend_q;
  logic       ext_pend_q;
  logic [7:0] key_code_q;
  logic       key_ext_q;
  logic       key_down_q;
  logic       key_event_q;
  logic [7:0] press_count_q;
  logic       ovf_seen_q;

  logic       match_d;
  logic [7:0] press_count_d;
  logic [7:0] key_ascii_d;

  // Same key (code and extension) as the one currently held
  always_comb begin
    match_d = key_down_q && (byte_q == key_code_q) && (ext_pend_q == key_ext_q);
  end

  // Press counter wraps naturally at 8 bits
  always_comb begin
    press_count_d = press_count_q + 8'd1;
  end

  // Handshake FSM plus scan-code decode; all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      nextdata_n_q  <= 1'b1;
      byte_q        <= 8'h00;
      brk_pend_q    <= 1'b0;
      ext_pend_q    <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_down_q    <= 1'b0;
      key_event_q   <= 1'b0;
      press_count_q <= 8'h00;
      ovf_seen_q    <= 1'b0;
    end else begin
      key_event_q <= 1'b0;
      if (rx.overflow) begin
        ovf_seen_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (rx.ready) begin
            byte_q       <= rx.data;
            nextdata_n_q <= 1'b0;
            state_q      <= S_ACK;
          end else begin
            nextdata_n_q <= 1'b1;
          end
        end
        S_ACK: begin
          nextdata_n_q <= 1'b1;
          state_q      <= S_IDLE;
          if (byte_q == BRK_PREFIX) begin
            brk_pend_q <= 1'b1;
          end else if (byte_q == EXT_PREFIX) begin
            ext_pend_q <= 1'b1;
          end else if (brk_pend_q) begin
            // Release: only the held key (incl. extension) drops key_down
            if (match_d) begin
              key_down_q <= 1'b0;
            end
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
          end else begin
            // Make: a repeat of the held key is typematic and ignored
            if (!match_d) begin
              key_code_q    <= byte_q;
              key_ext_q     <= ext_pend_q;
              key_down_q    <= 1'b1;
              press_count_q <= press_count_d;
              key_event_q   <= 1'b1;
            end
            ext_pend_q <= 1'b0;
          end
        end
        default: begin
          nextdata_n_q <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  // Set-2 code to ASCII; extended codes never map to a character
  always_comb begin
    key_ascii_d = 8'h00;
    if (!key_ext_q) begin
      case (key_code_q)
        8'h1C: key_ascii_d = 8'h61; // a
        8'h32: key_ascii_d = 8'h62; // b
        8'h21: key_ascii_d = 8'h63; // c
        8'h23: key_ascii_d = 8'h64; // d
        8'h24: key_ascii_d = 8'h65; // e
        8'h2B: key_ascii_d = 8'h66; // f
        8'h34: key_ascii_d = 8'h67; // g
        8'h33: key_ascii_d = 8'h68; // h
        8'h43: key_ascii_d = 8'h69; // i
        8'h3B: key_ascii_d = 8'h6A; // j
        8'h42: key_ascii_d = 8'h6B; // k
        8'h4B: key_ascii_d = 8'h6C; // l
        8'h3A: key_ascii_d = 8'h6D; // m
        8'h31: key_ascii_d = 8'h6E; // n
        8'h44: key_ascii_d = 8'h6F; // o
        8'h4D: key_ascii_d = 8'h70; // p
        8'h15: key_ascii_d = 8'h71; // q
        8'h2D: key_ascii_d = 8'h72; // r
        8'h1B: key_ascii_d = 8'h73; // s
        8'h2C: key_ascii_d = 8'h74; // t
        8'h3C: key_ascii_d = 8'h75; // u
        8'h2A: key_ascii_d = 8'h76; // v
        8'h1D: key_ascii_d = 8'h77; // w
        8'h22: key_ascii_d = 8'h78; // x
        8'h35: key_ascii_d = 8'h79; // y
        8'h1A: key_ascii_d = 8'h7A; // z
        8'h45: key_ascii_d = 8'h30; // 0
        8'h16: key_ascii_d = 8'h31; // 1
        8'h1E: key_ascii_d = 8'h32; // 2
        8'h26: key_ascii_d = 8'h33; // 3
        8'h25: key_ascii_d = 8'h34; // 4
        8'h2E: key_ascii_d = 8'h35; // 5
        8'h36: key_ascii_d = 8'h36; // 6
        8'h3D: key_ascii_d = 8'h37; // 7
        8'h3E: key_ascii_d = 8'h38; // 8
        8'h46: key_ascii_d = 8'h39; // 9
        8'h29: key_ascii_d = 8'h20; // space
        8'h5A: key_ascii_d = 8'h0D; // enter
        default: key_ascii_d = 8'h00;
      endcase
    end
  end

  assign rx.nextdata_n = nextdata_n_q;
  assign key_code      = key_code_q;
  assign key_ext       = key_ext_q;
  assign key_ascii     = key_ascii_d;
  assign key_down      = key_down_q;
  assign key_event     = key_event_q;
  assign press_count   = press_count_q;
  assign ovf_seen      = ovf_seen_q;

endmodule
